// File: rtl/vend_pkg.sv
// Shared encodings, FSM state constants and coin helpers for the vending payment controller.
package vend_pkg;

  localparam logic [1:0] CoinNickel  = 2'b00;
  localparam logic [1:0] CoinDime    = 2'b01;
  localparam logic [1:0] CoinQuarter = 2'b10;
  localparam logic [1:0] CoinDollar  = 2'b11;

  localparam logic [1:0] ChgNickel  = 2'b00;
  localparam logic [1:0] ChgDime    = 2'b01;
  localparam logic [1:0] ChgQuarter = 2'b10;

  localparam int unsigned ValNickel  = 5;
  localparam int unsigned ValDime    = 10;
  localparam int unsigned ValQuarter = 25;
  localparam int unsigned ValDollar  = 100;

  typedef logic [1:0] vend_state_t;

  localparam vend_state_t StIdle   = 2'd0;
  localparam vend_state_t StCheck  = 2'd1;
  localparam vend_state_t StVend   = 2'd2;
  localparam vend_state_t StChange = 2'd3;

  function automatic logic [6:0] coin_value(input logic [1:0] ctype);
    logic [6:0] val;
    unique case (ctype)
      CoinNickel:  val = 7'(ValNickel);
      CoinDime:    val = 7'(ValDime);
      CoinQuarter: val = 7'(ValQuarter);
      default:     val = 7'(ValDollar);
    endcase
    return val;
  endfunction

endpackage

// File: rtl/vend_change_gen.sv
// Greedy change-coin picker: largest of quarter/dime/nickel not exceeding the balance.
module vend_change_gen
  import vend_pkg::*;
#(
  parameter int unsigned BAL_W = 10
) (
  input  logic [BAL_W-1:0] balance_i,
  output logic [1:0]       coin_o,
  output logic [4:0]       value_o
);

  // Below a nickel the caller gates the output off, so nickel is a safe default.
  always_comb begin
    coin_o  = ChgNickel;
    value_o = 5'(ValNickel);
    if (balance_i >= BAL_W'(ValQuarter)) begin
      coin_o  = ChgQuarter;
      value_o = 5'(ValQuarter);
    end else if (balance_i >= BAL_W'(ValDime)) begin
      coin_o  = ChgDime;
      value_o = 5'(ValDime);
    end
  end

endmodule

// File: rtl/vend_payment_ctrl.sv
// Vending payment controller: coin credit, price check, vend handshake and greedy change.
// Optional credit-card payment path enabled by defining CREDIT_EN.
module vend_payment_ctrl
  import vend_pkg::*;
#(
  parameter int unsigned NUM_ITEMS = 8,
  parameter int unsigned PRICE_W   = 8,
  parameter int unsigned BAL_W     = 10,
  parameter int unsigned IDX_W     = $clog2(NUM_ITEMS)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         price_load,
  input  logic [NUM_ITEMS*PRICE_W-1:0] price_table,
  input  logic                         coin_valid,
  input  logic [1:0]                   coin_type,
  input  logic                         sel_valid,
  input  logic [IDX_W-1:0]             sel_index,
  input  logic                         cancel,
  output logic                         vend_req,
  output logic [IDX_W-1:0]             vend_index,
  input  logic                         vend_ack,
  output logic                         chg_valid,
  output logic [1:0]                   chg_coin,
  input  logic                         chg_ready,
  output logic [BAL_W-1:0]             balance,
  output logic                         coin_reject,
  output logic                         insufficient,
`ifdef CREDIT_EN
  input  logic                         pay_credit,
  input  logic                         credit_load,
  input  logic [BAL_W-1:0]             credit_value,
  output logic [BAL_W-1:0]             credit_bal,
`endif
  output logic                         busy
);

  localparam int unsigned SumW = BAL_W + 1;

  vend_state_t      state_q, state_d;
  logic [BAL_W-1:0] balance_q, balance_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             coin_reject_q, coin_reject_d;
  logic             insufficient_q, insufficient_d;
  logic [PRICE_W-1:0] price_q [NUM_ITEMS];

  logic [SumW-1:0]  coin_sum;
  logic [BAL_W-1:0] item_price, pay_bal, vend_rem;
  logic             sel_ok, cancel_ok, funds_ok, use_credit;
  logic [1:0]       chg_code;
  logic [4:0]       chg_val;

  assign coin_sum   = {1'b0, balance_q} + SumW'(coin_value(coin_type));
  assign item_price = BAL_W'(price_q[idx_q]);
  assign vend_rem   = balance_q - item_price;
  assign sel_ok     = sel_valid && (32'(sel_index) < NUM_ITEMS);
  assign cancel_ok  = cancel && (balance_q != '0);
  assign funds_ok   = pay_bal >= item_price;

`ifdef CREDIT_EN
  logic             credit_mode_q, credit_mode_d;
  logic [BAL_W-1:0] credit_bal_q, credit_bal_d;

  assign use_credit = credit_mode_q;
  assign pay_bal    = credit_mode_q ? credit_bal_q : balance_q;
  assign credit_bal = credit_bal_q;

  always_comb begin
    credit_mode_d = credit_mode_q;
    credit_bal_d  = credit_bal_q;
    if (state_q == StIdle) begin
      if (credit_load) credit_bal_d = credit_value;
      if (!cancel_ok && sel_ok) credit_mode_d = pay_credit;
    end else if (state_q == StVend && vend_ack && credit_mode_q) begin
      credit_bal_d = credit_bal_q - item_price;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      credit_mode_q <= 1'b0;
      credit_bal_q  <= '0;
    end else begin
      credit_mode_q <= credit_mode_d;
      credit_bal_q  <= credit_bal_d;
    end
  end
`else
  assign use_credit = 1'b0;
  assign pay_bal    = balance_q;
`endif

  vend_change_gen #(
    .BAL_W(BAL_W)
  ) u_change_gen (
    .balance_i(balance_q),
    .coin_o   (chg_code),
    .value_o  (chg_val)
  );

  always_comb begin
    state_d        = state_q;
    balance_d      = balance_q;
    idx_d          = idx_q;
    coin_reject_d  = coin_valid;
    insufficient_d = 1'b0;
    unique case (state_q)
      StIdle: begin
        // Priority: cancel, then selection, then coin; a displaced coin is rejected.
        if (cancel_ok) begin
          state_d = StChange;
        end else if (sel_ok) begin
          state_d = StCheck;
          idx_d   = sel_index;
        end else if (coin_valid && !coin_sum[BAL_W]) begin
          balance_d     = coin_sum[BAL_W-1:0];
          coin_reject_d = 1'b0;
        end
      end
      StCheck: begin
        if (cancel_ok) begin
          state_d = StChange;
        end else if (funds_ok) begin
          state_d = StVend;
        end else begin
          state_d        = StIdle;
          insufficient_d = 1'b1;
        end
      end
      StVend: begin
        if (vend_ack) begin
          state_d = StIdle;
          if (!use_credit) begin
            balance_d = vend_rem;
            if (vend_rem != '0) state_d = StChange;
          end
        end
      end
      StChange: begin
        if (balance_q < BAL_W'(ValNickel)) begin
          balance_d = '0;
          state_d   = StIdle;
        end else if (chg_ready) begin
          balance_d = balance_q - BAL_W'(chg_val);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q        <= StIdle;
      balance_q      <= '0;
      idx_q          <= '0;
      coin_reject_q  <= 1'b0;
      insufficient_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      balance_q      <= balance_d;
      idx_q          <= idx_d;
      coin_reject_q  <= coin_reject_d;
      insufficient_q <= insufficient_d;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned i = 0; i < NUM_ITEMS; i++) price_q[i] <= '0;
    end else if (state_q == StIdle && price_load) begin
      for (int unsigned i = 0; i < NUM_ITEMS; i++) begin
        price_q[i] <= price_table[i*PRICE_W +: PRICE_W];
      end
    end
  end

  assign vend_req     = (state_q == StVend);
  assign vend_index   = vend_req ? idx_q : '0;
  assign chg_valid    = (state_q == StChange) && (balance_q >= BAL_W'(ValNickel));
  assign chg_coin     = chg_valid ? chg_code : 2'b00;
  assign balance      = balance_q;
  assign coin_reject  = coin_reject_q;
  assign insufficient = insufficient_q;
  assign busy         = (state_q != StIdle);

endmodule

// File: tb/tb_vend_payment_ctrl.sv
// Self-checking bench for vend_payment_ctrl: coin table, directed corner sequences and
// randomized transactions against a transaction-level money model.
module tb_vend_payment_ctrl;

  localparam int unsigned NumItems = 8;
  localparam int unsigned PriceW   = 8;
  localparam int unsigned BalW     = 10;
  localparam int unsigned IdxW     = 3;
  localparam int          BalMax   = 1023;

  logic                       clk = 1'b0;
  logic                       rst = 1'b0;
  logic                       price_load = 1'b0;
  logic [NumItems*PriceW-1:0] price_table = '0;
  logic                       coin_valid = 1'b0;
  logic [1:0]                 coin_type = 2'b00;
  logic                       sel_valid = 1'b0;
  logic [IdxW-1:0]            sel_index = '0;
  logic                       cancel = 1'b0;
  logic                       vend_req;
  logic [IdxW-1:0]            vend_index;
  logic                       vend_ack = 1'b0;
  logic                       chg_valid;
  logic [1:0]                 chg_coin;
  logic                       chg_ready = 1'b0;
  logic [BalW-1:0]            balance;
  logic                       coin_reject;
  logic                       insufficient;
  logic                       busy;
`ifdef CREDIT_EN
  logic                       pay_credit = 1'b0;
  logic                       credit_load = 1'b0;
  logic [BalW-1:0]            credit_value = '0;
  logic [BalW-1:0]            credit_bal;
`endif

  always #5 clk = ~clk;

  vend_payment_ctrl #(
    .NUM_ITEMS(NumItems),
    .PRICE_W  (PriceW),
    .BAL_W    (BalW),
    .IDX_W    (IdxW)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .price_load  (price_load),
    .price_table (price_table),
    .coin_valid  (coin_valid),
    .coin_type   (coin_type),
    .sel_valid   (sel_valid),
    .sel_index   (sel_index),
    .cancel      (cancel),
    .vend_req    (vend_req),
    .vend_index  (vend_index),
    .vend_ack    (vend_ack),
    .chg_valid   (chg_valid),
    .chg_coin    (chg_coin),
    .chg_ready   (chg_ready),
    .balance     (balance),
    .coin_reject (coin_reject),
    .insufficient(insufficient),
`ifdef CREDIT_EN
    .pay_credit  (pay_credit),
    .credit_load (credit_load),
    .credit_value(credit_value),
    .credit_bal  (credit_bal),
`endif
    .busy        (busy)
  );

  int checks = 0;
  int errors = 0;
  int m_bal  = 0;
  int m_price [NumItems];

  typedef struct {
    int coin;
    int exp_bal;
    int exp_rej;
  } coin_vec_t;

  coin_vec_t vecs [15];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual %0d required %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int cval(input int t);
    case (t)
      0:       return 5;
      1:       return 10;
      2:       return 25;
      default: return 100;
    endcase
  endfunction

  task automatic set_prices();
    for (int i = 0; i < NumItems; i++) price_table[i*PriceW +: PriceW] = 8'(m_price[i]);
    price_load = 1'b1;
    tick();
    price_load = 1'b0;
  endtask

  task automatic insert_coin(input int t);
    int v;
    int rej;
    v = cval(t);
    coin_valid = 1'b1;
    coin_type  = 2'(t);
    tick();
    coin_valid = 1'b0;
    rej = (m_bal + v > BalMax) ? 1 : 0;
    if (rej == 0) m_bal += v;
    chk("coin_reject", 32'(coin_reject), rej);
    chk("coin_balance", 32'(balance), m_bal);
  endtask

  // Collect change coins and compare against the greedy breakdown of the amount.
  task automatic drain(input int amount, input int stall_idx, input int stall_len);
    int exp_q[$];
    int got_q[$];
    int r;
    int stall;
    int held;
    bit holding;
    r = amount;
    while (r >= 25) begin exp_q.push_back(2); r -= 25; end
    while (r >= 10) begin exp_q.push_back(1); r -= 10; end
    while (r >= 5)  begin exp_q.push_back(0); r -= 5;  end
    stall   = 0;
    held    = 0;
    holding = 1'b0;
    for (int cyc = 0; cyc < 400 && busy; cyc++) begin
      chg_ready = 1'b0;
      if (chg_valid) begin
        if (holding) begin
          chk("chg_coin_stable", 32'(chg_coin), held);
        end else begin
          holding = 1'b1;
          held    = int'(chg_coin);
          stall   = (got_q.size() == stall_idx) ? stall_len : 0;
        end
        if (stall > 0) begin
          stall--;
        end else begin
          chg_ready = 1'b1;
          got_q.push_back(int'(chg_coin));
          holding = 1'b0;
        end
      end
      tick();
    end
    chg_ready = 1'b0;
    chk("drain_done", 32'(busy), 0);
    chk("chg_count", got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) chk("chg_coin", got_q[i], exp_q[i]);
    chk("chg_balance", 32'(balance), 0);
    m_bal = 0;
  endtask

  task automatic select(input int idx, input int ack_dly, input int stall_idx, input int stall_len);
    int ok;
    int rem;
    sel_valid = 1'b1;
    sel_index = 3'(idx);
    tick();
    sel_valid = 1'b0;
    chk("check_busy", 32'(busy), 1);
    chk("check_no_req", 32'(vend_req), 0);
    tick();
    ok = (m_bal >= m_price[idx]) ? 1 : 0;
    chk("vend_req", 32'(vend_req), ok);
    chk("insufficient", 32'(insufficient), 1 - ok);
    if (ok == 1) begin
      for (int k = 0; k < ack_dly; k++) begin
        chk("vend_index", 32'(vend_index), idx);
        tick();
        chk("vend_req_hold", 32'(vend_req), 1);
      end
      chk("vend_index", 32'(vend_index), idx);
      vend_ack = 1'b1;
      tick();
      vend_ack = 1'b0;
      chk("vend_req_drop", 32'(vend_req), 0);
      rem = m_bal - m_price[idx];
      chk("vend_balance", 32'(balance), rem);
      m_bal = rem;
      if (rem > 0) drain(rem, stall_idx, stall_len);
      else chk("vend_idle", 32'(busy), 0);
    end else begin
      chk("insuff_balance", 32'(balance), m_bal);
      chk("insuff_idle", 32'(busy), 0);
    end
  endtask

  task automatic do_cancel(input int stall_idx, input int stall_len);
    int amt;
    amt = m_bal;
    cancel = 1'b1;
    tick();
    cancel = 1'b0;
    if (amt > 0) begin
      chk("cancel_busy", 32'(busy), 1);
      drain(amt, stall_idx, stall_len);
    end else begin
      chk("cancel_noop", 32'(busy), 0);
    end
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 10; i++) vecs[i] = '{3, 100 * (i + 1), 0};
    vecs[10] = '{3, 1000, 1};
    vecs[11] = '{2, 1000, 1};
    vecs[12] = '{1, 1010, 0};
    vecs[13] = '{1, 1020, 0};
    vecs[14] = '{0, 1020, 1};
    for (int i = 0; i < NumItems; i++) m_price[i] = 0;

    // Reset state
    repeat (2) tick();
    chk("rst_balance", 32'(balance), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_vend_req", 32'(vend_req), 0);
    chk("rst_chg_valid", 32'(chg_valid), 0);
    chk("rst_coin_reject", 32'(coin_reject), 0);
    chk("rst_insufficient", 32'(insufficient), 0);
    rst = 1'b1;
    tick();

    // Coin table up to and across the balance ceiling
    for (int i = 0; i < 15; i++) begin
      coin_valid = 1'b1;
      coin_type  = 2'(vecs[i].coin);
      tick();
      coin_valid = 1'b0;
      chk("tbl_balance", 32'(balance), vecs[i].exp_bal);
      chk("tbl_reject", 32'(coin_reject), vecs[i].exp_rej);
      m_bal = vecs[i].exp_bal;
    end
    tick();
    chk("reject_one_cycle", 32'(coin_reject), 0);
    do_cancel(5, 2);

    // Basic vend with one nickel change
    m_price = '{10, 20, 30, 65, 75, 0, 40, 55};
    set_prices();
    insert_coin(2);
    insert_coin(2);
    insert_coin(1);
    insert_coin(1);
    chk("bal_70", 32'(balance), 70);
    select(3, 3, 0, 0);

    // Insufficient funds
    insert_coin(2);
    insert_coin(2);
    select(4, 0, 0, 0);
    tick();
    chk("insuff_one_cycle", 32'(insufficient), 0);
    chk("insuff_bal_50", 32'(balance), 50);
    do_cancel(0, 0);

    // Refund 40 with the dime stalled three cycles
    insert_coin(2);
    insert_coin(1);
    insert_coin(0);
    do_cancel(1, 3);
    do_cancel(0, 0);

    // Coin and price_load during VEND are not honoured
    insert_coin(1);
    sel_valid = 1'b1;
    sel_index = 3'd0;
    tick();
    sel_valid = 1'b0;
    tick();
    chk("vend_entered", 32'(vend_req), 1);
    coin_valid = 1'b1;
    coin_type  = 2'd3;
    price_load = 1'b1;
    price_table = {NumItems{8'd200}};
    tick();
    coin_valid = 1'b0;
    price_load = 1'b0;
    chk("vend_coin_reject", 32'(coin_reject), 1);
    chk("vend_coin_balance", 32'(balance), 10);
    chk("vend_req_still", 32'(vend_req), 1);
    vend_ack = 1'b1;
    tick();
    vend_ack = 1'b0;
    chk("vend_done_bal", 32'(balance), 0);
    chk("vend_done_idle", 32'(busy), 0);
    m_bal = 0;
    insert_coin(1);
    select(0, 1, 0, 0);

    // Cancel, select and coin together with balance 30
    insert_coin(2);
    insert_coin(0);
    cancel     = 1'b1;
    sel_valid  = 1'b1;
    sel_index  = 3'd0;
    coin_valid = 1'b1;
    coin_type  = 2'd0;
    tick();
    cancel     = 1'b0;
    sel_valid  = 1'b0;
    coin_valid = 1'b0;
    chk("simul_reject", 32'(coin_reject), 1);
    chk("simul_balance", 32'(balance), 30);
    chk("simul_no_vend", 32'(vend_req), 0);
    chk("simul_chg_valid", 32'(chg_valid), 1);
    chk("simul_quarter", 32'(chg_coin), 2);
    drain(30, 0, 1);

    // Randomized transactions
    for (int n = 0; n < 300; n++) begin
      int op;
      op = int'($urandom_range(0, 99));
      if (op < 50) begin
        insert_coin(int'($urandom_range(0, 3)));
      end else if (op < 75) begin
        select(int'($urandom_range(0, NumItems - 1)), int'($urandom_range(0, 3)),
               int'($urandom_range(0, 4)), int'($urandom_range(0, 2)));
      end else if (op < 85) begin
        do_cancel(int'($urandom_range(0, 4)), int'($urandom_range(0, 2)));
      end else begin
        for (int i = 0; i < NumItems; i++) m_price[i] = int'($urandom_range(0, 120));
        set_prices();
      end
    end
    do_cancel(0, 0);

`ifdef CREDIT_EN
    // Credit vend leaves cash untouched and returns no change
    insert_coin(1);
    m_price[2] = 120;
    set_prices();
    credit_load  = 1'b1;
    credit_value = 10'd200;
    tick();
    credit_load = 1'b0;
    chk("credit_loaded", 32'(credit_bal), 200);
    pay_credit = 1'b1;
    sel_valid  = 1'b1;
    sel_index  = 3'd2;
    tick();
    sel_valid  = 1'b0;
    pay_credit = 1'b0;
    tick();
    chk("credit_vend_req", 32'(vend_req), 1);
    vend_ack = 1'b1;
    tick();
    vend_ack = 1'b0;
    chk("credit_bal_80", 32'(credit_bal), 80);
    chk("credit_cash_10", 32'(balance), 10);
    chk("credit_no_change", 32'(chg_valid), 0);
    chk("credit_idle", 32'(busy), 0);
`endif

    // Asynchronous reset mid-VEND
    if (m_bal < 10) insert_coin(1);
    m_price[6] = 5;
    set_prices();
    sel_valid = 1'b1;
    sel_index = 3'd6;
    tick();
    sel_valid = 1'b0;
    tick();
    chk("prerst_vend_req", 32'(vend_req), 1);
    #2;
    rst = 1'b0;
    #1;
    chk("arst_vend_req", 32'(vend_req), 0);
    chk("arst_vend_index", 32'(vend_index), 0);
    chk("arst_busy", 32'(busy), 0);
    chk("arst_balance", 32'(balance), 0);
    chk("arst_chg_valid", 32'(chg_valid), 0);
`ifdef CREDIT_EN
    chk("arst_credit_bal", 32'(credit_bal), 0);
`endif
    tick();
    rst = 1'b1;
    tick();
    m_bal = 0;
    for (int i = 0; i < NumItems; i++) m_price[i] = 0;
    // Cleared prices make item 5 free
    select(5, 0, 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
